// File: rtl/id_exe_stage_reg_if.sv
// rtl/id_exe_stage_reg_if.sv - ID/EXE pipeline payload bundle with decode-side and stage-side views
interface id_exe_stage_reg_if;
   logic        ID_WB_EN;
   logic        ID_MEM_R_EN;
   logic        ID_MEM_W_EN;
   logic        ID_B;
   logic        ID_S;
   logic [3:0]  ID_EXE_CMD;
   logic [31:0] ID_PC;
   logic [31:0] ID_Val_Rn;
   logic [31:0] ID_Val_Rm;
   logic        ID_imm;
   logic [11:0] ID_Shift_operand;
   logic [23:0] ID_Signed_imm_24;
   logic [3:0]  ID_Dest;
   logic [3:0]  ID_src1;
   logic [3:0]  ID_src2;
   logic [3:0]  ID_SR;

   logic        EXE_WB_EN;
   logic        EXE_MEM_R_EN;
   logic        EXE_MEM_W_EN;
   logic        EXE_B;
   logic        EXE_S;
   logic [3:0]  EXE_CMD;
   logic [31:0] EXE_PC;
   logic [31:0] EXE_Val_Rn;
   logic [31:0] EXE_Val_Rm;
   logic        EXE_imm;
   logic [11:0] EXE_Shift_operand;
   logic [23:0] EXE_Signed_imm_24;
   logic [3:0]  EXE_Dest;
   logic [3:0]  EXE_src1;
   logic [3:0]  EXE_src2;
   logic [3:0]  EXE_SR;
   logic        EXE_valid;

   modport master (
      output ID_WB_EN, ID_MEM_R_EN, ID_MEM_W_EN, ID_B, ID_S, ID_EXE_CMD,
             ID_PC, ID_Val_Rn, ID_Val_Rm, ID_imm, ID_Shift_operand,
             ID_Signed_imm_24, ID_Dest, ID_src1, ID_src2, ID_SR,
      input  EXE_WB_EN, EXE_MEM_R_EN, EXE_MEM_W_EN, EXE_B, EXE_S, EXE_CMD,
             EXE_PC, EXE_Val_Rn, EXE_Val_Rm, EXE_imm, EXE_Shift_operand,
             EXE_Signed_imm_24, EXE_Dest, EXE_src1, EXE_src2, EXE_SR, EXE_valid
   );

   modport slave (
      input  ID_WB_EN, ID_MEM_R_EN, ID_MEM_W_EN, ID_B, ID_S, ID_EXE_CMD,
             ID_PC, ID_Val_Rn, ID_Val_Rm, ID_imm, ID_Shift_operand,
             ID_Signed_imm_24, ID_Dest, ID_src1, ID_src2, ID_SR,
      output EXE_WB_EN, EXE_MEM_R_EN, EXE_MEM_W_EN, EXE_B, EXE_S, EXE_CMD,
             EXE_PC, EXE_Val_Rn, EXE_Val_Rm, EXE_imm, EXE_Shift_operand,
             EXE_Signed_imm_24, EXE_Dest, EXE_src1, EXE_src2, EXE_SR, EXE_valid
   );
endinterface

// File: rtl/id_exe_stage_reg.sv
// rtl/id_exe_stage_reg.sv - ID/EXE pipeline register with freeze, bubble insertion and saturating statistics
module id_exe_stage_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             hazard_detected,
   id_exe_stage_reg_if.slave pipe,
   output logic [CNT_W-1:0] bubble_count,
   output logic [CNT_W-1:0] flush_count
);
   localparam int PAY_W = 158;

   logic [PAY_W-1:0] id_pay;
   logic [PAY_W-1:0] exe_q;
   logic             valid_q;

   assign id_pay = {pipe.ID_WB_EN, pipe.ID_MEM_R_EN, pipe.ID_MEM_W_EN, pipe.ID_B, pipe.ID_S,
                    pipe.ID_EXE_CMD, pipe.ID_PC, pipe.ID_Val_Rn, pipe.ID_Val_Rm, pipe.ID_imm,
                    pipe.ID_Shift_operand, pipe.ID_Signed_imm_24, pipe.ID_Dest, pipe.ID_src1,
                    pipe.ID_src2, pipe.ID_SR};

   // Every EXE output comes straight from exe_q/valid_q, so nothing on ID reaches EXE combinationally.
   assign {pipe.EXE_WB_EN, pipe.EXE_MEM_R_EN, pipe.EXE_MEM_W_EN, pipe.EXE_B, pipe.EXE_S,
           pipe.EXE_CMD, pipe.EXE_PC, pipe.EXE_Val_Rn, pipe.EXE_Val_Rm, pipe.EXE_imm,
           pipe.EXE_Shift_operand, pipe.EXE_Signed_imm_24, pipe.EXE_Dest, pipe.EXE_src1,
           pipe.EXE_src2, pipe.EXE_SR} = exe_q;
   assign pipe.EXE_valid = valid_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         exe_q        <= '0;
         valid_q      <= 1'b0;
         bubble_count <= '0;
         flush_count  <= '0;
      end else if (!freeze) begin
         if (flush || hazard_detected) begin
            exe_q   <= '0;
            valid_q <= 1'b0;
            // A flush squashes the hazard too, so only the flush is counted.
            if (flush) begin
               if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
            end else if (bubble_count != '1) begin
               bubble_count <= bubble_count + CNT_W'(1);
            end
         end else begin
            exe_q   <= id_pay;
            valid_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb/tb_id_exe_stage_reg.sv - vector table and scoreboard bench for id_exe_stage_reg
module tb_id_exe_stage_reg;
   typedef struct packed {
      logic        wb, mr, mw, b, s;
      logic [3:0]  cmd;
      logic [31:0] pc, rn, rm;
      logic        imm;
      logic [11:0] shift;
      logic [23:0] simm;
      logic [3:0]  dest, src1, src2, sr;
   } pay_t;

   typedef struct {
      logic        rst, frz, fl, hz;
      pay_t        id;
      logic        ev;
      logic [15:0] eb, ef;
   } vec_t;

   typedef struct {
      pay_t        pay;
      logic        v;
      logic [15:0] b, f;
   } exp_t;

   logic clk = 1'b0;
   logic rst, freeze, flush, hazard_detected;
   pay_t id_pay, exe_pay, exe_pay_b;
   logic [15:0] bubble_count, flush_count;
   logic [1:0]  bubble_count_b, flush_count_b;

   int n_cmp = 0;
   int n_fail = 0;

   id_exe_stage_reg_if ifa ();
   id_exe_stage_reg_if ifb ();

   id_exe_stage_reg #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard_detected(hazard_detected),
      .pipe(ifa.slave), .bubble_count(bubble_count), .flush_count(flush_count));

   id_exe_stage_reg #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard_detected(hazard_detected),
      .pipe(ifb.slave), .bubble_count(bubble_count_b), .flush_count(flush_count_b));

   assign {ifa.ID_WB_EN, ifa.ID_MEM_R_EN, ifa.ID_MEM_W_EN, ifa.ID_B, ifa.ID_S, ifa.ID_EXE_CMD,
           ifa.ID_PC, ifa.ID_Val_Rn, ifa.ID_Val_Rm, ifa.ID_imm, ifa.ID_Shift_operand,
           ifa.ID_Signed_imm_24, ifa.ID_Dest, ifa.ID_src1, ifa.ID_src2, ifa.ID_SR} = id_pay;
   assign {ifb.ID_WB_EN, ifb.ID_MEM_R_EN, ifb.ID_MEM_W_EN, ifb.ID_B, ifb.ID_S, ifb.ID_EXE_CMD,
           ifb.ID_PC, ifb.ID_Val_Rn, ifb.ID_Val_Rm, ifb.ID_imm, ifb.ID_Shift_operand,
           ifb.ID_Signed_imm_24, ifb.ID_Dest, ifb.ID_src1, ifb.ID_src2, ifb.ID_SR} = id_pay;
   assign exe_pay = {ifa.EXE_WB_EN, ifa.EXE_MEM_R_EN, ifa.EXE_MEM_W_EN, ifa.EXE_B, ifa.EXE_S,
                     ifa.EXE_CMD, ifa.EXE_PC, ifa.EXE_Val_Rn, ifa.EXE_Val_Rm, ifa.EXE_imm,
                     ifa.EXE_Shift_operand, ifa.EXE_Signed_imm_24, ifa.EXE_Dest, ifa.EXE_src1,
                     ifa.EXE_src2, ifa.EXE_SR};
   assign exe_pay_b = {ifb.EXE_WB_EN, ifb.EXE_MEM_R_EN, ifb.EXE_MEM_W_EN, ifb.EXE_B, ifb.EXE_S,
                       ifb.EXE_CMD, ifb.EXE_PC, ifb.EXE_Val_Rn, ifb.EXE_Val_Rm, ifb.EXE_imm,
                       ifb.EXE_Shift_operand, ifb.EXE_Signed_imm_24, ifb.EXE_Dest, ifb.EXE_src1,
                       ifb.EXE_src2, ifb.EXE_SR};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_pay(input string name, input pay_t act, input pay_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic pay_t rnd_pay();
      pay_t p;
      p.wb = 1'($urandom());   p.mr = 1'($urandom());   p.mw = 1'($urandom());
      p.b = 1'($urandom());    p.s = 1'($urandom());    p.cmd = 4'($urandom());
      p.pc = $urandom();       p.rn = $urandom();       p.rm = $urandom();
      p.imm = 1'($urandom());  p.shift = 12'($urandom()); p.simm = 24'($urandom());
      p.dest = 4'($urandom()); p.src1 = 4'($urandom()); p.src2 = 4'($urandom());
      p.sr = 4'($urandom());
      return p;
   endfunction

   function automatic vec_t mk(input logic r, input logic fz, input logic f, input logic h,
                               input pay_t p, input logic v, input int eb, input int ef);
      vec_t x;
      x.rst = r; x.frz = fz; x.fl = f; x.hz = h; x.id = p;
      x.ev = v; x.eb = 16'(eb); x.ef = 16'(ef);
      return x;
   endfunction

   vec_t vec[16];
   exp_t sb[$];
   int   sat_q[$];
   pay_t model;

   initial begin
      pay_t p;
      exp_t e;
      rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard_detected = 1'b0;
      id_pay = rnd_pay();
      model = '0;

      vec[0] = mk(0, 0, 0, 0, rnd_pay(), 0, 0, 0);
      p = rnd_pay(); p.dest = 4'd5; p.wb = 1'b1; p.rn = 32'h1234;
      vec[1] = mk(1, 0, 0, 0, p, 1, 0, 0);
      p = rnd_pay(); p.wb = 1'b1;
      vec[2] = mk(1, 0, 0, 1, p, 0, 1, 0);
      vec[3] = mk(1, 0, 0, 1, p, 0, 2, 0);
      vec[4] = mk(1, 0, 1, 1, rnd_pay(), 0, 2, 1);
      p = rnd_pay(); p.pc = 32'h40;
      vec[5] = mk(1, 0, 0, 0, p, 1, 2, 1);
      vec[6] = mk(1, 1, 1, 0, rnd_pay(), 1, 2, 1);
      vec[7] = mk(1, 1, 1, 0, rnd_pay(), 1, 2, 1);
      vec[8] = mk(1, 1, 1, 0, rnd_pay(), 1, 2, 1);
      vec[9] = mk(1, 1, 0, 1, rnd_pay(), 1, 2, 1);
      vec[10] = mk(1, 0, 1, 0, rnd_pay(), 0, 2, 2);
      vec[11] = mk(1, 0, 0, 0, rnd_pay(), 1, 2, 2);
      vec[12] = mk(0, 1, 1, 1, rnd_pay(), 0, 0, 0);
      vec[13] = mk(1, 0, 0, 0, rnd_pay(), 1, 0, 0);
      vec[14] = mk(1, 0, 0, 1, rnd_pay(), 0, 1, 0);
      vec[15] = mk(1, 0, 0, 0, rnd_pay(), 1, 1, 0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rst = vec[i].rst; freeze = vec[i].frz; flush = vec[i].fl; hazard_detected = vec[i].hz;
         id_pay = vec[i].id;
         #1;
         if (i > 0) chk_pay($sformatf("v%0d pre-edge hold", i), exe_pay, model);
         if (!vec[i].rst) model = '0;
         else if (vec[i].frz) model = model;
         else if (vec[i].fl || vec[i].hz) model = '0;
         else model = vec[i].id;
         e.pay = model; e.v = vec[i].ev; e.b = vec[i].eb; e.f = vec[i].ef;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk_pay($sformatf("v%0d payload", i), exe_pay, e.pay);
         chk($sformatf("v%0d valid", i), 32'(ifa.EXE_valid), 32'(e.v));
         chk($sformatf("v%0d bubble_count", i), 32'(bubble_count), 32'(e.b));
         chk($sformatf("v%0d flush_count", i), 32'(flush_count), 32'(e.f));
      end
      chk("v1 dest", 32'(vec[1].id.dest), 32'd5);

      @(negedge clk);
      rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard_detected = 1'b0;
      sat_q.push_back(0);
      @(posedge clk);
      #1;
      chk("sat reset", 32'(bubble_count_b), 32'(sat_q.pop_front()));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         rst = 1'b1; hazard_detected = 1'b1; id_pay = rnd_pay();
         sat_q.push_back((k + 1 > 3) ? 3 : k + 1);
         @(posedge clk);
         #1;
         chk($sformatf("sat bubble_count k%0d", k), 32'(bubble_count_b), 32'(sat_q.pop_front()));
         chk($sformatf("sat flush_count k%0d", k), 32'(flush_count_b), 32'd0);
         chk_pay($sformatf("sat payload k%0d", k), exe_pay_b, '0);
      end

      @(negedge clk);
      hazard_detected = 1'b0; flush = 1'b1;
      @(posedge clk);
      #1;
      chk("sat flush after hazards", 32'(flush_count_b), 32'd1);
      chk("sat bubble held", 32'(bubble_count_b), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/id_exe_stage_reg.md
ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the bubble and flush statistics counters.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-low (0 = reset), sampled on rising clk.
REQ-004 SHALL have port freeze  in  1  memory-stall hold; 1 = all state holds.
REQ-005 SHALL have port flush  in  1  branch taken in EXE; 1 = insert bubble.
REQ-006 SHALL have port hazard_detected  in  1  from hazard detection unit; 1 = ID contents not issuable, insert bubble.
REQ-007 SHALL have port pair ID_WB_EN / EXE_WB_EN  in/out  1  register-file write enable.
REQ-008 SHALL have port pair ID_MEM_R_EN / EXE_MEM_R_EN  in/out  1  load; EXE_MEM_R_EN feeds hazard unit EX_MEM_R_EN.
REQ-009 SHALL have port pair ID_MEM_W_EN / EXE_MEM_W_EN  in/out  1  store.
REQ-010 SHALL have port pair ID_B / EXE_B  in/out  1  branch.
REQ-011 SHALL have port pair ID_S / EXE_S  in/out  1  update status flags.
REQ-012 SHALL have port pair ID_EXE_CMD / EXE_CMD  in/out  4  ALU command.
REQ-013 SHALL have port pairs ID_PC / EXE_PC, ID_Val_Rn / EXE_Val_Rn, ID_Val_Rm / EXE_Val_Rm  in/out  32 each  PC and operand values.
REQ-014 SHALL have port pairs ID_imm / EXE_imm (1), ID_Shift_operand / EXE_Shift_operand (12), ID_Signed_imm_24 / EXE_Signed_imm_24 (24)  in/out  immediate fields.
REQ-015 SHALL have port pairs ID_Dest / EXE_Dest, ID_src1 / EXE_src1, ID_src2 / EXE_src2, ID_SR / EXE_SR  in/out  4 each  register indices and status flags; EXE_Dest feeds hazard unit.
REQ-016 SHALL have port EXE_valid  out  1  1 = EXE holds a real instruction.
REQ-017 SHALL have ports bubble_count, flush_count  out  CNT_W each  statistics.

Function
REQ-018 SHALL evaluate per edge in priority: rst=0, else freeze=1, else flush=1, else hazard_detected=1, else load.
REQ-019 Load SHALL copy every ID_* input to its EXE_* output and set EXE_valid=1; latency exactly one clk.
REQ-020 Bubble (flush or hazard) SHALL clear every EXE_* output, including data fields, to 0 and set EXE_valid=0.
REQ-021 Freeze SHALL hold all outputs and both counters unchanged, even if flush or hazard_detected is 1.
REQ-022 Hazard bubble SHALL increment bubble_count by 1; flush bubble SHALL increment flush_count by 1; flush and hazard together SHALL count only flush.
REQ-023 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-024 Outputs SHALL be driven only from registers; no combinational path from any input to any output.
REQ-025 Consecutive hazard cycles SHALL each insert one bubble and each increment bubble_count.

Reset
REQ-026 rst=0 on an edge SHALL clear all EXE_* outputs, EXE_valid, bubble_count and flush_count to 0, overriding freeze, flush and hazard.
REQ-027 rst asserted mid-stream SHALL discard the held instruction; first edge after rst=1 behaves per REQ-018.

Verification
REQ-028 Load: ID_Dest=5, ID_WB_EN=1, ID_Val_Rn=0x1234 -> next edge EXE_Dest=5, EXE_WB_EN=1, EXE_Val_Rn=0x1234, EXE_valid=1.
REQ-029 Hazard: hazard_detected=1 for 2 cycles with ID_WB_EN=1 -> two edges of EXE_WB_EN=0, EXE_Dest=0, EXE_valid=0; bubble_count 0->2.
REQ-030 Simultaneous: flush=1 and hazard_detected=1 one cycle -> bubble; flush_count=1, bubble_count unchanged.
REQ-031 Freeze: load PC=0x40, then freeze=1 with flush=1 for 3 cycles -> EXE_PC stays 0x40, EXE_valid=1, counters unchanged.
REQ-032 Saturation: CNT_W=2, hazard 5 cycles -> bubble_count 1,2,3,3,3.
REQ-033 Reset: after loads and counters nonzero, rst=0 with freeze=1 one edge -> all outputs 0; rst=1 then load -> EXE_valid=1 next edge.
